// File: rtl/riscv_pkg.sv
// Shared RV32I opcode classes and hazard-controller state encoding.
// The immediate generator decodes instruction formats from the same constants.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StMemErr  = 2'd2
    } hc_state_e;

endpackage

// File: rtl/src_use_dec.sv
// Opcode to source-register usage decode for load-use hazard detection.
module src_use_dec
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       rs1_used_o,
    output logic       rs2_used_o
);

    always_comb begin
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        case (opcode_i)
            OP_REG, OP_STORE, OP_BRANCH: begin
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                rs1_used_o = 1'b1;
            end
            // Register fields of U/J-type words are immediate bits, never sources.
            OP_LUI, OP_AUIPC, OP_JAL: begin
                rs1_used_o = 1'b0;
            end
            default: begin
                rs1_used_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stage enables, flushes, PC redirect,
// dmem freeze with timeout watchdog, and saturating hazard statistics.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_inst,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_sel_target,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int unsigned     WdW    = $clog2(MEM_TIMEOUT);
    localparam logic [WdW-1:0]  WdOne  = WdW'(1);
    localparam logic [WdW-1:0]  WdLast = WdW'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    hc_state_e        state_q, state_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic rs1_used, rs2_used, load_use, run_rules;
    logic unused_inst_bits;

    assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CntOne;
    endfunction

    src_use_dec u_src_use_dec (
        .opcode_i   (id_inst[6:0]),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((rs1_used && (ex_rd == id_inst[19:15])) ||
                       (rs2_used && (ex_rd == id_inst[24:20])));

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        run_rules     = 1'b0;
        pc_write      = 1'b1;
        pc_sel_target = 1'b0;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_write  = 1'b1;

        case (state_q)
            StRun: begin
                if (dmem_req && !dmem_ready) begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
                    state_d    = StMemWait;
                    wd_d       = WdOne;
                    wait_cnt_d = sat_inc(wait_cnt_q);
                end else begin
                    run_rules = 1'b1;
                end
            end
            StMemWait: begin
                if (!dmem_ready) begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
                    wait_cnt_d = sat_inc(wait_cnt_q);
                    wd_d       = wd_q + WdOne;
                    if (wd_q == WdLast) begin
                        state_d = StMemErr;
                    end
                end else begin
                    // Release cycle: EX was frozen, so a pending redirect is still valid.
                    state_d   = StRun;
                    run_rules = 1'b1;
                end
            end
            StMemErr: begin
                {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
            end
            default: begin
                {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
                state_d = StRun;
            end
        endcase

        if (run_rules) begin
            if (ex_redirect) begin
                pc_sel_target = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                flush_cnt_d   = sat_inc(flush_cnt_q);
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
        end

        if (reset) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
            pc_sel_target = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            wd_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign mem_err   = (state_q == StMemErr);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It generates per-stage write-enables, flushes and the PC-redirect select. It detects load-use hazards from the ID-stage instruction word, using the same opcode classes as the immediate generator. It freezes the pipeline during multi-cycle data-memory accesses, with a timeout watchdog and hazard statistics counters.

Parameters:
MEM_TIMEOUT, 64, max consecutive dmem wait cycles before sticky error (>=2)
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
id_inst  input  32  instruction word currently in ID
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  5  destination register of instruction in EX
ex_redirect  input  1  EX resolved taken branch, JAL or JALR
dmem_req  input  1  MEM stage is issuing a data-memory access
dmem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC register enable
pc_sel_target  output  1  1 = PC loads EX target, 0 = PC+4
if_id_write  output  1  IF/ID register enable
if_id_flush  output  1  IF/ID loads a bubble (NOP)
id_ex_write  output  1  ID/EX register enable
id_ex_flush  output  1  ID/EX loads a bubble
ex_mem_write  output  1  EX/MEM register enable
mem_wb_write  output  1  MEM/WB register enable
mem_err  output  1  sticky dmem timeout flag
stall_cnt  output  CNT_W  load-use stall cycles
flush_cnt  output  CNT_W  redirect events
wait_cnt  output  CNT_W  dmem wait cycles

Behaviour:
- Control outputs are combinational functions of the current state and this cycle's inputs. State, the watchdog and the statistics counters are registered.
- Reset (asynchronous, active-high): state=RUN; watchdog=0; mem_err=0; all counters=0. While reset is high, all *_write=0, both flushes=1, pc_sel_target=0.
- Source-use decode from id_inst[6:0]:
  - rs1 used for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - rs2 used for 0110011, 0100011, 1100011.
  - 0110111, 0010111, 1101111 and unknown opcodes use no sources.
- load_use = ex_mem_read && ex_rd!=0 && ((rs1_used && ex_rd==id_inst[19:15]) || (rs2_used && ex_rd==id_inst[24:20])).
- FSM states: RUN, MEM_WAIT, MEM_ERR.
- RUN (default: all *_write=1, flushes=0, pc_sel_target=0). Priority is mem > redirect > load-use.
  - dmem_req && !dmem_ready: all *_write=0, no flush. Go to MEM_WAIT, watchdog<=1, wait_cnt++.
  - else ex_redirect: pc_sel_target=1, if_id_flush=1, id_ex_flush=1, flush_cnt++. Load-use is ignored, because the ID instruction is squashed.
  - else load_use: pc_write=0, if_id_write=0, id_ex_flush=1, stall_cnt++. This yields exactly one bubble per hazard.
- MEM_WAIT:
  - If !dmem_ready: all *_write=0, wait_cnt++, watchdog++. If watchdog==MEM_TIMEOUT-1, go to MEM_ERR.
  - If dmem_ready: return to RUN and, in this same cycle, evaluate the redirect and load-use rules as in RUN. The mem rule is treated as satisfied.
- MEM_ERR: all *_write=0, mem_err=1. Held until reset.
- ex_redirect arriving during MEM_WAIT is not lost: EX is frozen, so it stays asserted and is acted on in the release cycle.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Shared package riscv_pkg: opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_REG, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC) and the FSM enum typedef. The immediate generator reuses the same opcode constants.
- One sub-module, src_use_dec: combinational opcode -> {rs1_used, rs2_used}.

Test Plan:
- Load-use hit: ex_mem_read=1, ex_rd=5, id_inst=0x00728333 (add x6,x5,x7) -> for one cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1.
- No false stalls: ex_rd=5 with id_inst=0x000052B7 (lui x5); ex_rd=0 with id_inst=0x00100093 (addi x1,x0,1) -> no stall, stall_cnt stays 0.
- Redirect over load-use: ex_redirect=1 plus the load-use hit above -> pc_sel_target=1, both flushes=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> all *_write=0 for 3 cycles and 1 in the 4th; wait_cnt=3; state returns to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_req=1, dmem_ready never asserted -> mem_err=1 after the 4th wait cycle and stays set. An asynchronous reset pulse mid-cycle clears mem_err and all counters immediately.
- Redirect held across wait: ex_redirect=1 together with a 2-cycle dmem stall -> flush and redirect occur only in the release cycle; flush_cnt=1.
